mux_display_scanner: RTL and testbench
======================================

Name: mux_display_scanner

Overview:
- Parametrised, time-multiplexed N-digit seven-segment driver for the slot machine's won/credit readouts.
- Scans one digit per slot. BCD values are double-buffered and committed only at frame boundaries, so the display never tears.
- Adds leading-zero blanking, per-digit blink, dash display for non-BCD codes, and inter-digit dead time against ghosting.
- Sits between the game/credit logic and the PNP digit-enable transistors plus the shared segment bus.

Parameters:
- NUM_DIGITS, 5: number of digits scanned; must be ≥2.
- SCAN_DIV, 40000: clk cycles per digit slot; must be > DEAD_CYCLES.
- DEAD_CYCLES, 200: cycles at the start of each slot during which all enables are off.
- BLINK_FRAMES, 16: frames per blink half-period; must be ≥1.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its seg bit is 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures digits_in
- digits_in  in  4*NUM_DIGITS  BCD nibbles; nibble i = bits [4i+3:4i]; digit 0 is rightmost
- lz_blank_en  in  1  enables leading-zero blanking
- blink_mask  in  NUM_DIGITS  bit i set means digit i blinks
- pending  out  1  staged value not yet committed
- enable_sel  out  NUM_DIGITS  one-hot active-high digit enable; bit i drives digit i
- seg  out  7  segments; seg[0]=a … seg[6]=g

Behaviour:
- Reset (async, reset_n=0):
  - prescaler=0, scan index=NUM_DIGITS-1, frame counter=0, blink phase=0.
  - staging=0, active=0, pending=0.
  - enable_sel=0; seg=all segments off (7'h7F when SEG_ACTIVE_LOW=1).
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when prescaler==SCAN_DIV-1.
- Scan index:
  - On tick, decrements; wraps from 0 to NUM_DIGITS-1.
  - The 0→NUM_DIGITS-1 transition is frame_wrap.
  - Scan order is MSB digit first.
- Frame counter:
  - Increments on frame_wrap.
  - On reaching BLINK_FRAMES-1 with frame_wrap, it clears and blink phase toggles.
- load / commit rules:
  - load without frame_wrap: staging<=digits_in, pending<=1.
  - frame_wrap, no load, pending=1: active<=staging, pending<=0.
  - load and frame_wrap in the same cycle: active<=digits_in, staging<=digits_in, pending<=0.
  - Repeated loads before commit: last one wins.
- Digit visibility:
  - Digit i is blanked if blink_mask[i] && blink_phase==1.
  - Digit i is also blanked if lz_blank_en && i!=0 && active nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never leading-zero blanked.
- Decode:
  - Nibble 0–9 gives standard segments.
  - Nibble 10–15 gives a dash (g only).
  - Polarity is applied per SEG_ACTIVE_LOW.
- Outputs:
  - Registered; they reflect the current index/prescaler with 1-cycle latency.
  - enable_sel is 0 while prescaler<DEAD_CYCLES.
  - enable_sel is 0 throughout the slot if the digit is blanked.
  - Otherwise enable_sel = 1<<index.
  - seg=off whenever enable_sel==0; otherwise seg = decoded active nibble.
- Invariants:
  - enable_sel is always zero or one-hot.
  - seg never changes while enable_sel is non-zero within a slot, except when an active-register commit occurs; commits happen only at frame_wrap, which lands in dead time.
- Reset mid-frame:
  - Outputs go off immediately (async).
  - Scanning restarts at digit NUM_DIGITS-1.
  - Any staged value is discarded.

Decomposition:
- Package display_pkg:
  - SEG_* 7-bit constants for 0–9, DASH and OFF, in active-high form.
  - Function bcd_to_seg(nibble) returning active-high segments.
  - localparam widths derived via $clog2.
- Sub-module scan_timer, holding prescaler, index, tick, frame_wrap, frame counter and blink phase.
  - Parameters: NUM_DIGITS, SCAN_DIV, BLINK_FRAMES.
- Top level holds staging/active registers, blanking logic and the output registers.

Test Plan (NUM_DIGITS=5, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1):
- Reset release, lz_blank_en=0:
  - enable_sel stays 0 for 2 cycles, then 5'b10000 with seg=7'b1000000 for 3 cycles.
  - Then 0 for 1 cycle, then 5'b01000, continuing down to 5'b00001 and wrapping.
- load digits_in=20'h00305 mid-frame:
  - pending=1 immediately; displayed digits stay 0 until frame_wrap; pending=0 next cycle.
  - Digit 2 then shows seg=7'b0110000 ('3').
- lz_blank_en=1 with active=20'h00305:
  - Slots for digits 4 and 3 have enable_sel=0 and seg off.
  - Digit 1 shows '0'.
- active=20'h00000, lz_blank_en=1:
  - Only digit 0 is enabled; it shows '0'.
- blink_mask=5'b00001:
  - Digit 0 is enabled in frames 0–1, blanked in frames 2–3, enabled again in frames 4–5.
- Edge cases:
  - load with digits_in=20'h0000C: digit 0 shows dash (seg=7'b0111111).
  - load asserted exactly on the frame_wrap cycle: commits directly, pending stays 0.
  - reset_n pulsed low mid-slot: outputs go off asynchronously.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
// Segment patterns are kept active-high here; polarity is applied at the pins.
package display_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Segment bit order: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g
    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // BCD nibble to active-high segments; codes 10..15 show a dash.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [NIBBLE_W-1:0] nibble);
        logic [SEG_W-1:0] s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/frame timebase for the display scanner: prescaler, digit index
// (MSB digit first), frame wrap strobe and blink phase.
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int SCAN_DIV     = 40000,
    parameter int BLINK_FRAMES = 16,
    localparam int PRESC_W     = cnt_width(SCAN_DIV),
    localparam int IDX_W       = cnt_width(NUM_DIGITS),
    localparam int FRAME_W     = cnt_width(BLINK_FRAMES)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [PRESC_W-1:0] prescaler,
    output logic [IDX_W-1:0]   index,
    output logic               frame_wrap,
    output logic               blink_phase
);

    logic               tick;
    logic [FRAME_W-1:0] frame_count;

    // tick closes a digit slot; frame_wrap closes the slot of digit 0,
    // which is the last one scanned in a frame.
    assign tick       = (prescaler == PRESC_W'(SCAN_DIV - 1));
    assign frame_wrap = tick && (index == '0);

    // Prescaler: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESC_W'(1);
        end
    end

    // Digit index: counts down once per slot, restarting at the top digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index <= IDX_W'(NUM_DIGITS - 1);
        end else if (tick) begin
            if (index == '0) begin
                index <= IDX_W'(NUM_DIGITS - 1);
            end else begin
                index <= index - IDX_W'(1);
            end
        end
    end

    // Frame counter and blink phase: phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_count == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_display_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// double buffering, leading-zero blanking, per-digit blink and dead time.
//
// load handshake: load is a one-cycle strobe with no back-pressure.
// digits_in is sampled on every cycle load is high (last one wins);
// pending stays high while a captured value waits for the next frame
// boundary, and drops the cycle after it reaches the active register.
module mux_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 5,
    parameter int SCAN_DIV       = 40000,
    parameter int DEAD_CYCLES    = 200,
    parameter int BLINK_FRAMES   = 16,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
    input  logic                           lz_blank_en,
    input  logic [NUM_DIGITS-1:0]          blink_mask,
    output logic                           pending,
    output logic [NUM_DIGITS-1:0]          enable_sel,
    output logic [SEG_W-1:0]               seg
);

    localparam int PRESC_W = cnt_width(SCAN_DIV);
    localparam int IDX_W   = cnt_width(NUM_DIGITS);
    localparam int DATA_W  = NIBBLE_W * NUM_DIGITS;

    // XOR mask that turns active-high patterns into pin levels.
    localparam logic [SEG_W-1:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;
    localparam logic [SEG_W-1:0] SEG_IDLE = SEG_OFF ^ POL_MASK;

    logic [PRESC_W-1:0]    prescaler;
    logic [IDX_W-1:0]      index;
    logic                  frame_wrap;
    logic                  blink_phase;

    logic [DATA_W-1:0]     staging;
    logic [DATA_W-1:0]     active;

    logic                  above_zero;
    logic [NUM_DIGITS-1:0] lz_zero;
    logic [NUM_DIGITS-1:0] blanked;
    logic [NIBBLE_W-1:0]   cur_nibble;
    logic                  show;

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .prescaler   (prescaler),
        .index       (index),
        .frame_wrap  (frame_wrap),
        .blink_phase (blink_phase)
    );

    // Double buffer: loads land in staging and are promoted only at a frame
    // wrap. A load on the wrap cycle itself goes straight to active. The wrap
    // cycle is the last cycle of digit 0's slot, so the new value first
    // appears during the dead time of the next slot and never tears a digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (load && frame_wrap) begin
            staging <= digits_in;
            active  <= digits_in;
            pending <= 1'b0;
        end else if (load) begin
            staging <= digits_in;
            pending <= 1'b1;
        end else if (frame_wrap && pending) begin
            active  <= staging;
            pending <= 1'b0;
        end
    end

    // Per-digit blanking: lz_zero[i] means digits i and above are all zero.
    always_comb begin
        above_zero = 1'b1;
        lz_zero    = '0;
        blanked    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero && (active[NIBBLE_W*i +: NIBBLE_W] == '0);
            lz_zero[i] = above_zero;
            blanked[i] = (blink_mask[i] && blink_phase)
                      || (lz_blank_en && (i != 0) && lz_zero[i]);
        end
    end

    // Current digit's nibble and whether it may be driven this cycle.
    assign cur_nibble = active[{index, 2'b00} +: NIBBLE_W];
    assign show       = (32'(prescaler) >= DEAD_CYCLES) && !blanked[index];

    // Registered pin drivers: segments are forced off whenever no digit is
    // enabled so the shared bus is quiet during dead time and blanked slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_sel <= '0;
            seg        <= SEG_IDLE;
        end else if (show) begin
            enable_sel <= NUM_DIGITS'(1) << index;
            seg        <= bcd_to_seg(cur_nibble) ^ POL_MASK;
        end else begin
            enable_sel <= '0;
            seg        <= SEG_IDLE;
        end
    end

endmodule

// File: tb/tb_mux_display_scanner.sv
// Bench for mux_display_scanner: table-driven reset/decode checks, hand-written
// frame-level sequences and randomized load/blank/blink traffic, all compared
// cycle by cycle against a timeline model built from absolute cycle counts.
module tb_mux_display_scanner;

  localparam int N         = 5;
  localparam int SD        = 4;
  localparam int DEAD      = 1;
  localparam int BF        = 2;
  localparam int FRAME_LEN = SD * N;

  typedef struct {
    int         cycles;
    logic [4:0] en;
    logic [6:0] seg;
  } run_vec_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [19:0] digits_in;
  logic        lz_blank_en;
  logic [4:0]  blink_mask;
  logic        pending;
  logic [4:0]  enable_sel;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  // timeline model state
  int          t;
  logic [19:0] m_act;
  logic [19:0] m_stg;
  logic        m_pend;
  logic [12:0] exp_q[$];

  // per-frame observations
  int         fr_cnt[N];
  logic [6:0] fr_seg[N];

  run_vec_t run_vec[12];
  dec_vec_t dec_vec[16];
  int       blink_exp[6];

  mux_display_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV(SD),
    .DEAD_CYCLES(DEAD),
    .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .digits_in(digits_in),
    .lz_blank_en(lz_blank_en),
    .blink_mask(blink_mask),
    .pending(pending),
    .enable_sel(enable_sel),
    .seg(seg)
  );

  // clock / watchdog
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
    end
  endtask

  // active-low glyph for a nibble
  function automatic logic [6:0] seg_lut(input int nib);
    logic [6:0] g;
    case (nib)
      0: g = 7'b0111111;
      1: g = 7'b0000110;
      2: g = 7'b1011011;
      3: g = 7'b1001111;
      4: g = 7'b1100110;
      5: g = 7'b1101101;
      6: g = 7'b1111101;
      7: g = 7'b0000111;
      8: g = 7'b1111111;
      9: g = 7'b1101111;
      default: g = 7'b1000000;
    endcase
    return ~g;
  endfunction

  // one clock: predict outputs from the absolute timeline, then compare
  task automatic step();
    int p, slot, idx, frame, ph, nib;
    bit blank, vis, wrap;
    logic [4:0] e_en;
    logic [6:0] e_seg;
    logic [12:0] e;
    @(posedge clk);
    p     = t % SD;
    slot  = t / SD;
    idx   = N - 1 - (slot % N);
    frame = slot / N;
    ph    = (frame / BF) % 2;
    blank = (blink_mask[idx] && ph == 1)
         || (lz_blank_en && idx != 0 && ((m_act >> (4 * idx)) == 20'h0));
    vis   = (p >= DEAD) && !blank;
    nib   = int'((m_act >> (4 * idx)) & 20'hF);
    e_en  = vis ? 5'(1 << idx) : 5'h0;
    e_seg = vis ? seg_lut(nib) : 7'h7F;
    wrap  = (t % FRAME_LEN) == FRAME_LEN - 1;
    if (load && wrap) begin
      m_act = digits_in; m_stg = digits_in; m_pend = 0;
    end else if (load) begin
      m_stg = digits_in; m_pend = 1;
    end else if (wrap && m_pend) begin
      m_act = m_stg; m_pend = 0;
    end
    t++;
    exp_q.push_back({m_pend, e_en, e_seg});
    #1;
    e = exp_q.pop_front();
    chk("pending", pending, e[12]);
    chk("enable_sel", enable_sel, e[11:7]);
    chk("seg", seg, e[6:0]);
    chk("onehot", ($countones(enable_sel) <= 1), 1);
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    chk("rst_enable_sel", enable_sel, 0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_pending", pending, 0);
    load = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    t = 0; m_act = 0; m_stg = 0; m_pend = 0;
  endtask

  task automatic load_value(input logic [19:0] v);
    digits_in = v;
    load = 1;
    step();
    load = 0;
  endtask

  task automatic run_frame();
    for (int d = 0; d < N; d++) begin
      fr_cnt[d] = 0;
      fr_seg[d] = 7'h7F;
    end
    repeat (FRAME_LEN) begin
      step();
      for (int d = 0; d < N; d++) begin
        if (enable_sel[d]) begin
          fr_cnt[d]++;
          fr_seg[d] = seg;
        end
      end
    end
  endtask

  initial begin
    int n;
    logic [6:0] cap;
    reset_n = 1; load = 0; digits_in = 0; lz_blank_en = 0; blink_mask = 0;

    run_vec = '{
      '{1, 5'b00000, 7'h7F}, '{3, 5'b10000, 7'b1000000},
      '{1, 5'b00000, 7'h7F}, '{3, 5'b01000, 7'b1000000},
      '{1, 5'b00000, 7'h7F}, '{3, 5'b00100, 7'b1000000},
      '{1, 5'b00000, 7'h7F}, '{3, 5'b00010, 7'b1000000},
      '{1, 5'b00000, 7'h7F}, '{3, 5'b00001, 7'b1000000},
      '{1, 5'b00000, 7'h7F}, '{3, 5'b10000, 7'b1000000}
    };
    dec_vec = '{
      '{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
      '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
      '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h3F}, '{4'hB, 7'h3F},
      '{4'hC, 7'h3F}, '{4'hD, 7'h3F}, '{4'hE, 7'h3F}, '{4'hF, 7'h3F}
    };
    blink_exp = '{3, 3, 0, 0, 3, 3};

    // reset release scan sequence
    do_reset();
    foreach (run_vec[k]) begin
      for (int c = 0; c < run_vec[k].cycles; c++) begin
        step();
        chk("rst_seq_en", enable_sel, run_vec[k].en);
        chk("rst_seq_seg", seg, run_vec[k].seg);
      end
    end

    // decode table on digit 0, upper digits non-zero
    foreach (dec_vec[k]) begin
      load_value({16'h1234, dec_vec[k].nib});
      cap = 7'h7F;
      repeat (2 * FRAME_LEN) begin
        step();
        if (enable_sel == 5'b00001) cap = seg;
      end
      chk("decode", cap, dec_vec[k].seg);
    end

    // load mid-frame: pending until the frame wrap, then digit 2 shows '3'
    do_reset();
    repeat (7) step();
    load_value(20'h00305);
    chk("pend_set", pending, 1);
    n = 0;
    while (pending && n < 40) begin
      step();
      n++;
    end
    chk("commit_latency", n, FRAME_LEN - 1 - 7);
    run_frame();
    chk("digit2_three", fr_seg[2], 7'b0110000);
    chk("digit4_zero_shown", fr_seg[4], 7'b1000000);

    // leading-zero blanking of 00305
    lz_blank_en = 1;
    run_frame();
    chk("lz_digit4_cnt", fr_cnt[4], 0);
    chk("lz_digit3_cnt", fr_cnt[3], 0);
    chk("lz_digit2_cnt", fr_cnt[2], SD - DEAD);
    chk("lz_digit1_zero", fr_seg[1], 7'b1000000);

    // all-zero value: only digit 0 lit
    load_value(20'h00000);
    repeat (FRAME_LEN - 1) step();
    run_frame();
    chk("zero_digit0_cnt", fr_cnt[0], SD - DEAD);
    chk("zero_others_cnt", fr_cnt[1] + fr_cnt[2] + fr_cnt[3] + fr_cnt[4], 0);
    chk("zero_digit0_seg", fr_seg[0], 7'b1000000);

    // blink on digit 0 over six frames
    lz_blank_en = 0;
    do_reset();
    blink_mask = 5'b00001;
    for (int f = 0; f < 6; f++) begin
      run_frame();
      chk("blink_digit0", fr_cnt[0], blink_exp[f]);
      chk("blink_digit4", fr_cnt[4], SD - DEAD);
    end
    blink_mask = 0;

    // load exactly on the frame wrap cycle
    while ((t % FRAME_LEN) != FRAME_LEN - 1) step();
    load_value(20'h98765);
    chk("wrap_load_pending", pending, 0);
    run_frame();
    chk("wrap_load_digit4", fr_seg[4], 7'h10);
    chk("wrap_load_digit0", fr_seg[0], 7'h12);

    // reset mid-slot with a staged value outstanding
    load_value(20'h11111);
    n = 0;
    while (enable_sel == 0 && n < 10) begin
      step();
      n++;
    end
    chk("midslot_lit", (enable_sel != 0), 1);
    do_reset();
    run_frame();
    run_frame();
    chk("staged_discarded", fr_seg[0], 7'b1000000);

    // randomized traffic
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) begin
        lz_blank_en = 1'($urandom_range(0, 1));
        blink_mask  = 5'($urandom_range(0, 31));
      end
      n = $urandom_range(0, 5);
      digits_in = 20'h0;
      for (int d = 0; d < n; d++) digits_in[4*d +: 4] = 4'($urandom_range(0, 11));
      load = ($urandom_range(0, 9) == 0);
      step();
      load = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
